// File: rtl/vector_line_plotter.sv
// Bresenham line rasteriser: turns beam segments into a stream of pixel writes.
// Optional macro VLP_CLIP_EN suppresses points outside the H_ACTIVE x V_ACTIVE window.
module vector_line_plotter #(
   parameter int COORD_W  = 10,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic               clk_96MHz,
   input  logic               RESET_n,
   input  logic               seg_valid,
   output logic               seg_ready,
   input  logic [COORD_W-1:0] seg_x0,
   input  logic [COORD_W-1:0] seg_y0,
   input  logic [COORD_W-1:0] seg_x1,
   input  logic [COORD_W-1:0] seg_y1,
   input  logic [3:0]         seg_z,
   input  logic [3:0]         seg_color,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic [3:0]         pix_z,
   output logic [3:0]         pix_color,
   output logic               busy,
   output logic [15:0]        pix_count
);

   localparam int EW = COORD_W + 2;

   typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

   function automatic logic signed [EW-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                      input logic [COORD_W-1:0] b);
      abs_diff = (a >= b) ? EW'(a - b) : EW'(b - a);
   endfunction

   function automatic logic is_clipped(input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] y);
`ifdef VLP_CLIP_EN
      is_clipped = (32'(x) >= H_ACTIVE) || (32'(y) >= V_ACTIVE);
`else
      is_clipped = &{1'b0, x, y};
`endif
   endfunction

   state_t                r_state;
   logic                  r_pix_valid;
   logic [COORD_W-1:0]    r_cx, r_cy;
   logic [3:0]            r_z, r_color;
   logic [15:0]           r_count;

   logic [COORD_W-1:0]    r_x0, r_y0, r_x1, r_y1;
   logic signed [EW-1:0]  r_dx, r_dy, r_err;
   logic                  r_sx, r_sy;

   logic signed [EW:0]    w_e2, w_dx_e, w_dy_e;
   logic                  w_step_x, w_step_y, w_last, w_adv;
   logic signed [EW-1:0]  w_err_next;
   logic [COORD_W-1:0]    w_nx, w_ny;

   // Both step decisions read the pre-update error term.
   assign w_e2       = {r_err, 1'b0};
   assign w_dx_e     = (EW+1)'(r_dx);
   assign w_dy_e     = (EW+1)'(r_dy);
   assign w_step_x   = (w_e2 >= w_dy_e);
   assign w_step_y   = (w_e2 <= w_dx_e);
   assign w_err_next = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);
   assign w_nx       = w_step_x ? (r_sx ? r_cx + 1'b1 : r_cx - 1'b1) : r_cx;
   assign w_ny       = w_step_y ? (r_sy ? r_cy + 1'b1 : r_cy - 1'b1) : r_cy;
   assign w_last     = (r_cx == r_x1) && (r_cy == r_y1);
   // A point retires on a pixel handshake, or immediately when it was suppressed.
   assign w_adv      = (r_state == DRAW) && (!r_pix_valid || pix_ready);

   always_ff @(posedge clk_96MHz) begin
      if (!RESET_n) begin
         r_state     <= IDLE;
         r_pix_valid <= 1'b0;
         r_cx        <= '0;
         r_cy        <= '0;
         r_z         <= '0;
         r_color     <= '0;
         r_count     <= '0;
      end else begin
         if (r_pix_valid && pix_ready)
            r_count <= r_count + 1'b1;
         case (r_state)
            IDLE: begin
               if (seg_valid) begin
                  r_z     <= seg_z;
                  r_color <= seg_color;
                  if (seg_z != 4'd0)
                     r_state <= SETUP;
               end
            end
            SETUP: begin
               r_cx        <= r_x0;
               r_cy        <= r_y0;
               r_pix_valid <= !is_clipped(r_x0, r_y0);
               r_state     <= DRAW;
            end
            DRAW: begin
               if (w_adv) begin
                  if (w_last) begin
                     r_pix_valid <= 1'b0;
                     r_state     <= IDLE;
                  end else begin
                     r_cx        <= w_nx;
                     r_cy        <= w_ny;
                     r_pix_valid <= !is_clipped(w_nx, w_ny);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_96MHz) begin
      if (r_state == IDLE && seg_valid) begin
         r_x0 <= seg_x0;
         r_y0 <= seg_y0;
         r_x1 <= seg_x1;
         r_y1 <= seg_y1;
      end
      if (r_state == SETUP) begin
         r_dx  <= abs_diff(r_x1, r_x0);
         r_dy  <= -abs_diff(r_y1, r_y0);
         r_sx  <= (r_x1 > r_x0);
         r_sy  <= (r_y1 > r_y0);
         r_err <= abs_diff(r_x1, r_x0) - abs_diff(r_y1, r_y0);
      end else if (w_adv && !w_last) begin
         r_err <= w_err_next;
      end
   end

   assign seg_ready = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign pix_valid = r_pix_valid;
   assign pix_x     = r_cx;
   assign pix_y     = r_cy;
   assign pix_z     = r_z;
   assign pix_color = r_color;
   assign pix_count = r_count;

endmodule

// File: tb/tb_vector_line_plotter.sv
// Scoreboard bench for vector_line_plotter: directed segments, queue-based pixel checking.
module tb_vector_line_plotter;
   localparam int COORD_W = 10;

   logic               clk = 1'b0;
   logic               RESET_n;
   logic               seg_valid, seg_ready;
   logic [COORD_W-1:0] seg_x0, seg_y0, seg_x1, seg_y1;
   logic [3:0]         seg_z, seg_color;
   logic               pix_valid, pix_ready;
   logic [COORD_W-1:0] pix_x, pix_y;
   logic [3:0]         pix_z, pix_color;
   logic               busy;
   logic [15:0]        pix_count;

   always #5 clk = ~clk;

   vector_line_plotter #(.COORD_W(COORD_W), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
      .clk_96MHz(clk), .RESET_n(RESET_n),
      .seg_valid(seg_valid), .seg_ready(seg_ready),
      .seg_x0(seg_x0), .seg_y0(seg_y0), .seg_x1(seg_x1), .seg_y1(seg_y1),
      .seg_z(seg_z), .seg_color(seg_color),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_z(pix_z), .pix_color(pix_color),
      .busy(busy), .pix_count(pix_count)
   );

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [3:0]         z;
      logic [3:0]         c;
   } pix_t;

   pix_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   npix = 0;
   int   last_edge = 0;
   int   t_xfer = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: a pixel transfers at the posedge following a negedge with valid && ready.
   logic prev_stall = 1'b0;
   pix_t prev_pix;
   always @(negedge clk) begin
      if (RESET_n) begin
         if (prev_stall) begin
            check("stall_valid", int'(pix_valid), 1);
            check("stall_hold", int'({pix_x, pix_y, pix_z, pix_color} == prev_pix), 1);
         end
         if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", pix_x, pix_y);
            end else begin
               pix_t e;
               e = exp_q.pop_front();
               check("pix_x", int'(pix_x), int'(e.x));
               check("pix_y", int'(pix_y), int'(e.y));
               check("pix_z", int'(pix_z), int'(e.z));
               check("pix_color", int'(pix_color), int'(e.c));
            end
            npix++;
            last_edge = cyc + 1;
         end
         prev_stall = pix_valid && !pix_ready;
         prev_pix   = {pix_x, pix_y, pix_z, pix_color};
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic push(input int x, input int y, input int z, input int c);
      pix_t p;
      p.x = COORD_W'(x); p.y = COORD_W'(y); p.z = 4'(z); p.c = 4'(c);
      exp_q.push_back(p);
   endtask

   // Called at a negedge; returns at the negedge after the transfer edge.
   task automatic send_seg(input int x0, input int y0, input int x1, input int y1,
                           input int z, input int c);
      int n;
      seg_x0 = COORD_W'(x0); seg_y0 = COORD_W'(y0);
      seg_x1 = COORD_W'(x1); seg_y1 = COORD_W'(y1);
      seg_z = 4'(z); seg_color = 4'(c); seg_valid = 1'b1;
      n = 0;
      while (!seg_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("seg_accept_timeout", int'(seg_ready), 1);
      t_xfer = cyc + 1;
      @(negedge clk);
      seg_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      logic done;
      n = 0;
      done = (exp_q.size() == 0) && !busy;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
         done = (exp_q.size() == 0) && !busy;
      end
      check("drain_timeout", int'(done), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int f, n, t1, t2, nb;
      logic drained;
      RESET_n = 1'b0; pix_ready = 1'b1;
      seg_valid = 1'b1; seg_x0 = 10'd1; seg_y0 = 10'd1; seg_x1 = 10'd5; seg_y1 = 10'd5;
      seg_z = 4'd7; seg_color = 4'd7;

      // Reset with a pending segment
      repeat (3) begin
         @(negedge clk);
         check("rst_seg_ready", int'(seg_ready), 1);
         check("rst_pix_valid", int'(pix_valid), 0);
         check("rst_pix_count", int'(pix_count), 0);
         check("rst_busy", int'(busy), 0);
      end
      check("rst_pix_xyzc", int'({pix_x, pix_y, pix_z, pix_color}), 0);
      seg_valid = 1'b0;
      @(posedge clk); #1 RESET_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", int'(busy), 0);

      // Horizontal segment
      for (int x = 10; x <= 14; x++) push(x, 20, 5, 3);
      npix = 0;
      send_seg(10, 20, 14, 20, 5, 3);
      n = 0;
      while (!pix_valid && n < 20) begin @(negedge clk); n++; end
      f = cyc + 1;
      check("horiz_latency", f - t_xfer, 2);
      wait_idle(100);
      check("horiz_npix", npix, 5);
      check("horiz_span", last_edge - f, 4);
      check("horiz_count", int'(pix_count), 5);
      check("horiz_z", int'(pix_z), 5);
      check("horiz_color", int'(pix_color), 3);

      // Steep reverse diagonal with back-pressure
      push(7,9,9,12); push(7,8,9,12); push(6,7,9,12); push(6,6,9,12); push(6,5,9,12);
      push(5,4,9,12); push(5,3,9,12); push(5,2,9,12); push(4,1,9,12); push(4,0,9,12);
      npix = 0;
      send_seg(7, 9, 4, 0, 9, 12);
      drained = 1'b0;
      for (int i = 0; i < 200 && !drained; i++) begin
         @(posedge clk); #1;
         pix_ready = ~pix_ready;
         drained = (exp_q.size() == 0) && !busy;
      end
      check("diag_drained", int'(drained), 1);
      pix_ready = 1'b1;
      @(negedge clk);
      check("diag_npix", npix, 10);
      check("diag_count", int'(pix_count), 15);

      // Blank move followed by zero-length segment
      npix = 0;
      send_seg(300, 300, 5, 5, 0, 7);
      t1 = t_xfer;
      check("blank_ready", int'(seg_ready), 1);
      push(100, 100, 1, 2);
      send_seg(100, 100, 100, 100, 1, 2);
      t2 = t_xfer;
      check("blank_turnaround", t2 - t1, 1);
      wait_idle(50);
      check("zero_npix", npix, 1);
      check("zero_count", int'(pix_count), 16);

      // Reset in the middle of a long segment
      for (int x = 0; x < 3; x++) push(x, 0, 2, 4);
      npix = 0;
      send_seg(0, 0, 50, 0, 2, 4);
      n = 0;
      while (npix < 3 && n < 50) begin @(posedge clk); n++; end
      check("mid_reach3", npix, 3);
      #1 RESET_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_pix_valid", int'(pix_valid), 0);
      check("mid_busy", int'(busy), 0);
      check("mid_seg_ready", int'(seg_ready), 1);
      check("mid_count", int'(pix_count), 0);
      check("mid_queue", exp_q.size(), 0);
      @(posedge clk); #1 RESET_n = 1'b1;
      @(negedge clk);
      check("mid_after_valid", int'(pix_valid), 0);
      check("mid_npix", npix, 3);

`ifdef VLP_CLIP_EN
      // Segment crossing the right edge of the clip window
      for (int x = 636; x <= 639; x++) push(x, 10, 6, 1);
      npix = 0;
      send_seg(636, 10, 643, 10, 6, 1);
      nb = 0;
      for (int i = 0; i < 50 && busy; i++) begin
         nb++;
         @(negedge clk);
      end
      check("clip_busy_cycles", nb, 9);
      check("clip_npix", npix, 4);
      check("clip_count", int'(pix_count), 4);
`else
      // Without clipping, off-screen points are still emitted
      for (int x = 638; x <= 641; x++) push(x, 5, 6, 1);
      npix = 0;
      send_seg(638, 5, 641, 5, 6, 1);
      nb = 0;
      wait_idle(50);
      check("noclip_npix", npix + nb, 4);
      check("noclip_count", int'(pix_count), 4);
`endif

      check("final_queue", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/vector_line_plotter.md
Name: vector_line_plotter

Overview:
- Sits downstream of the vector generator (vg_top) inside the Tempest core.
- Consumes one beam segment per vector-generator draw: start point, end point, intensity and colour.
- Rasterises each segment with integer Bresenham stepping into a stream of pixel writes for the framebuffer writer.
- Blank moves (intensity 0) reposition the beam and emit no pixels.

Parameters:
- COORD_W, 10, width of the X/Y screen coordinate.
- H_ACTIVE, 640, visible width in pixels; the clip window is X in 0..H_ACTIVE-1.
- V_ACTIVE, 480, visible height in pixels; the clip window is Y in 0..V_ACTIVE-1.

Ports:
- clk_96MHz  input  1  system clock. Every register is clocked on its rising edge.
- RESET_n  input  1  reset: synchronous, active-low.
- seg_valid  input  1  segment descriptor is valid.
- seg_ready  output  1  block can accept a segment.
- seg_x0  input  COORD_W  start X, unsigned.
- seg_y0  input  COORD_W  start Y, unsigned.
- seg_x1  input  COORD_W  end X, unsigned.
- seg_y1  input  COORD_W  end Y, unsigned.
- seg_z  input  4  intensity; 0 means blank move.
- seg_color  input  4  colour index.
- pix_valid  output  1  pixel write is valid.
- pix_ready  input  1  framebuffer writer accepts the pixel.
- pix_x  output  COORD_W  pixel X.
- pix_y  output  COORD_W  pixel Y.
- pix_z  output  4  pixel intensity, latched from seg_z.
- pix_color  output  4  pixel colour, latched from seg_color.
- busy  output  1  high in any state other than IDLE.
- pix_count  output  16  count of pixels accepted since reset. Wraps at 65535 -> 0.

Behaviour:
- Reset (RESET_n low at a clock edge):
  - state = IDLE; seg_ready = 1; pix_valid = 0; busy = 0.
  - pix_x, pix_y, pix_z, pix_color = 0; pix_count = 0.
  - Reset asserted mid-segment abandons the segment. No further pixels are emitted and no segment is accepted during reset.
- Handshakes:
  - Segment transfer: seg_valid && seg_ready at a clock edge.
  - Pixel transfer: pix_valid && pix_ready at a clock edge.
  - seg_ready = 1 only in IDLE.
  - While pix_valid = 1 and pix_ready = 0, pix_* must hold stable.
- State IDLE:
  - On segment transfer, latch all seg_* fields.
  - seg_z = 0: stay in IDLE. Update nothing else; no pixels. The next segment may transfer on the following cycle.
  - seg_z != 0: go to SETUP.
- State SETUP (exactly 1 cycle):
  - dx = |x1-x0|; dy = -|y1-y0|.
  - sx = +1 if x1 > x0, else -1; sy likewise from y1, y0.
  - err = dx+dy, signed, COORD_W+2 bits.
  - Current point (cx,cy) = (x0,y0).
  - Go to DRAW.
- State DRAW:
  - Present (cx,cy) on pix_x/pix_y with pix_valid = 1, unless the point is suppressed by clipping (see Optional Feature).
  - The point advances when the pixel transfers, or in a single cycle when it is suppressed.
  - If (cx,cy) == (x1,y1), go to IDLE; seg_ready rises the next cycle.
  - Otherwise, with e2 = 2*err:
    - if e2 >= dy: err += dy, cx += sx.
    - if e2 <= dx: err += dx, cy += sy.
    - Both updates use the pre-update err.
- Pixel count and latency:
  - Pixels per segment = max(|dx|,|dy|) + 1; endpoints are inclusive.
  - A zero-length segment (x0 = x1, y0 = y1, z != 0) emits exactly one pixel.
  - First pixel_valid appears 2 cycles after the segment transfer edge.
  - With pix_ready held high: 1 pixel per cycle. Back-to-back segments have 2 dead cycles between them (DRAW->IDLE, then SETUP).
- pix_count increments on each pixel transfer only. Suppressed pixels are not counted.
- Coordinates never wrap during stepping, because the walk is bounded by the endpoints.

Optional Feature:
- Macro: VLP_CLIP_EN.
- Defined:
  - Points with cx >= H_ACTIVE or cy >= V_ACTIVE are suppressed: pix_valid stays 0 for that point, and the point advances in one cycle.
  - A fully off-screen segment emits nothing but still occupies DRAW for max(|dx|,|dy|)+1 cycles.
- Undefined: every point is emitted, and the downstream writer is responsible for bounds.

Test Plan:
- Reset sequence: hold RESET_n low 3 cycles with seg_valid = 1 -> seg_ready = 1, pix_valid = 0, pix_count = 0, no segment transfers during reset.
- Horizontal segment (10,20)->(14,20), z = 5, color = 3, pix_ready = 1:
  - pixels x = 10..14 at y = 20 on 5 consecutive cycles;
  - first pixel 2 cycles after transfer;
  - pix_z = 5, pix_color = 3; pix_count = 5.
- Steep reverse diagonal (7,9)->(4,0), pix_ready toggling 1/0:
  - exactly 10 pixels, y = 9 down to 0, endpoints (7,9) and (4,0) included;
  - outputs stable on every stalled cycle.
- Blank move then zero-length segment:
  - z = 0 segment: accepted in 1 cycle, no pixels;
  - (100,100)->(100,100), z = 1: exactly one pixel (100,100).
- Reset mid-segment: (0,0)->(50,0); assert RESET_n low after the 3rd pixel -> pix_valid = 0 on the next cycle, state IDLE, pix_count = 0.
- VLP_CLIP_EN defined, segment (636,10)->(643,10) with H_ACTIVE = 640:
  - only x = 636..639 emitted; pix_count = 4;
  - busy stays high 8 DRAW cycles.
